// File: rtl/puerto_es_bus_pkg.sv
// -----------------------------------------------------------------------------
// puerto_es_bus_pkg
// Shared definitions for the memory-mapped I/O responder puerto_es_bus:
//   - default base word address of the 4-word register window
//   - register offsets inside the window (enum reg_off_e)
//   - bit positions inside the ESTADO status word
//   - pack_estado(): assembles the ESTADO word from its individual fields
// -----------------------------------------------------------------------------
package puerto_es_bus_pkg;

   // Word address of register 0; the low two bits must stay zero so the
   // window is naturally aligned.
   localparam logic [15:0] BASE_DEFAULT = 16'h0010;

   // Register offsets inside the window.
   typedef enum logic [1:0] {
      OFF_PUERTO = 2'd0,
      OFF_RX     = 2'd1,
      OFF_ESTADO = 2'd2,
      OFF_TEMP   = 2'd3
   } reg_off_e;

   // ESTADO bit positions.
   localparam int EST_NO_VACIO   = 0;
   localparam int EST_LLENO      = 1;
   localparam int EST_SUBDESB    = 2;
   localparam int EST_DESBORDE   = 3;
   localparam int EST_EXPIRADO   = 4;
   localparam int EST_CUENTA_LSB = 5;
   localparam int EST_IE         = 8;

   // Builds the status word; every bit not listed here reads as zero.
   function automatic logic [15:0] pack_estado(
      input logic       no_vacio,
      input logic       lleno,
      input logic       subdesb,
      input logic       desborde,
      input logic       expirado,
      input logic [2:0] cuenta,
      input logic       ie
   );
      logic [15:0] e;
      e                        = '0;
      e[EST_NO_VACIO]          = no_vacio;
      e[EST_LLENO]             = lleno;
      e[EST_SUBDESB]           = subdesb;
      e[EST_DESBORDE]          = desborde;
      e[EST_EXPIRADO]          = expirado;
      e[EST_CUENTA_LSB +: 3]   = cuenta;
      e[EST_IE]                = ie;
      return e;
   endfunction

endpackage

// File: rtl/puerto_es_bus_if.sv
// -----------------------------------------------------------------------------
// puerto_es_bus_if
// Shared CPU bus as seen by the I/O responder.
//   Direcciones      16  word address
//   DatosEntrada     16  write data sampled from the shared Datos bus
//   DatosSalida      16  read data, gated onto Datos by an external tri-state
//   HabilitarSalida   1  tri-state enable for DatosSalida
//   oe                1  read strobe
//   WR                1  write strobe
// modport master: the CPU side; modport slave: the responder side.
// -----------------------------------------------------------------------------
interface puerto_es_bus_if;

   logic [15:0] Direcciones;
   logic [15:0] DatosEntrada;
   logic [15:0] DatosSalida;
   logic        HabilitarSalida;
   logic        oe;
   logic        WR;

   modport master (
      output Direcciones,
      output DatosEntrada,
      output oe,
      output WR,
      input  DatosSalida,
      input  HabilitarSalida
   );

   modport slave (
      input  Direcciones,
      input  DatosEntrada,
      input  oe,
      input  WR,
      output DatosSalida,
      output HabilitarSalida
   );

endinterface

// File: rtl/puerto_es_bus_fifo_rx.sv
// -----------------------------------------------------------------------------
// puerto_es_bus_fifo_rx
// Receive FIFO: circular buffer with wrapping read/write pointers and an
// explicit occupancy count.
//   clk       clock, all state on rising edge
//   rst_n     synchronous active-low reset (empties the FIFO)
//   push      push request; accepted when not full, or when full with a pop
//   pop       pop request; ignored while empty
//   din       word to push
//   dout      current head word (only meaningful while not empty)
//   full      count == DEPTH
//   empty     count == 0
//   count     occupancy, 0..DEPTH
//   overflow  one-cycle pulse: push refused because full with no pop
// DEPTH must be a power of two, at least 2, so the pointers wrap for free.
// -----------------------------------------------------------------------------
module puerto_es_bus_fifo_rx #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [15:0]              din,
   output logic [15:0]              dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic [15:0]   mem_q [DEPTH];
   logic          pop_ok;
   logic          push_ok;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // still accepted when it coincides with a pop.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CW'(DEPTH));
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      overflow = push & full & ~pop_ok;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: emptiness is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/puerto_es_bus.sv
// -----------------------------------------------------------------------------
// puerto_es_bus
// Memory-mapped I/O responder on the shared Datos/Direcciones bus. Answers
// the same oe / WR strobes as the memory, but only inside its 4-word window
// BASE..BASE+3:
//   +0 PUERTO        latched output port (read/write)
//   +1 RX            read pops the receive FIFO head; empty read returns 0
//                    and sets underflow
//   +2 ESTADO        status word; any read clears underflow/overflow/expired
//   +3 TEMPORIZADOR  write loads reload value and counter; read returns counter
// Ports:
//   Reloj          clock, all state on rising edge
//   Reiniciar      synchronous active-low reset
//   bus            puerto_es_bus_if.slave (address, data, strobes, read enable)
//   EntradaDato    producer data for the RX FIFO
//   EntradaValida  producer push request
//   EntradaListo   FIFO not full (low while in reset)
//   PuertoSalida   output-port register
//   Interrupcion   only with PUERTO_ES_IRQ_EN: expired | (not empty & IE)
// Optional feature macro: PUERTO_ES_IRQ_EN (adds Interrupcion and the
// writable IE bit, ESTADO bit 8).
// -----------------------------------------------------------------------------
module puerto_es_bus
   import puerto_es_bus_pkg::*;
#(
   parameter logic [15:0] BASE        = BASE_DEFAULT,
   parameter int          PROFUNDIDAD = 4
) (
   input  logic                Reloj,
   input  logic                Reiniciar,
   puerto_es_bus_if.slave      bus,
   input  logic [15:0]         EntradaDato,
   input  logic                EntradaValida,
   output logic                EntradaListo,
   output logic [15:0]         PuertoSalida
`ifdef PUERTO_ES_IRQ_EN
   ,
   output logic                Interrupcion
`endif
);

   localparam int CW = $clog2(PROFUNDIDAD) + 1;

   logic           sel;
   reg_off_e       off;
   logic           rd_fire;
   logic           wr_fire;
   logic           estado_clr;
   logic           expire_evt;
   logic [15:0]    estado;
   logic           ie_bit;

   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_ovf;
   logic [15:0]    fifo_head;
   logic [CW-1:0]  fifo_count;

   logic           oe_q,        oe_d;
   logic           wr_q,        wr_d;
   logic [15:0]    port_q,      port_d;
   logic           underflow_q, underflow_d;
   logic           overflow_q,  overflow_d;
   logic           expired_q,   expired_d;
   logic [15:0]    cnt_q,       cnt_d;
   logic [15:0]    reload_q,    reload_d;
`ifdef PUERTO_ES_IRQ_EN
   logic           ie_q,        ie_d;
`endif

   // Address decode and strobe edge detection. A strobe only acts on its
   // first cycle, so a strobe held for several cycles has a single effect.
   // With both strobes high the access is a write and the read side effects
   // are suppressed.
   always_comb begin
      sel        = (bus.Direcciones[15:2] == BASE[15:2]);
      off        = reg_off_e'(bus.Direcciones[1:0]);
      rd_fire    = sel & bus.oe & ~oe_q & ~bus.WR;
      wr_fire    = sel & bus.WR & ~wr_q;
      fifo_pop   = rd_fire & (off == OFF_RX) & ~fifo_empty;
      estado_clr = rd_fire & (off == OFF_ESTADO);
   end

   puerto_es_bus_fifo_rx #(
      .DEPTH (PROFUNDIDAD)
   ) u_fifo_rx (
      .clk      (Reloj),
      .rst_n    (Reiniciar),
      .push     (EntradaValida),
      .pop      (fifo_pop),
      .din      (EntradaDato),
      .dout     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .overflow (fifo_ovf)
   );

`ifdef PUERTO_ES_IRQ_EN
   assign ie_bit       = ie_q;
   assign Interrupcion = expired_q | (~fifo_empty & ie_q);
`else
   assign ie_bit       = 1'b0;
`endif

   // Zero-wait-state read path: data is valid in the same cycle oe rises,
   // and is forced to zero whenever this block does not own Datos.
   always_comb begin
      estado = pack_estado(~fifo_empty, fifo_full, underflow_q, overflow_q,
                           expired_q, 3'(fifo_count), ie_bit);
      bus.HabilitarSalida = bus.oe & sel & ~bus.WR;
      bus.DatosSalida     = '0;
      if (bus.HabilitarSalida) begin
         case (off)
            OFF_PUERTO: bus.DatosSalida = port_q;
            OFF_RX:     bus.DatosSalida = fifo_empty ? 16'h0000 : fifo_head;
            OFF_ESTADO: bus.DatosSalida = estado;
            OFF_TEMP:   bus.DatosSalida = cnt_q;
            default:    bus.DatosSalida = '0;
         endcase
      end
   end

   // Next-state for port register, sticky flags and timer. Flag events raised
   // in the same cycle as an ESTADO read win over the clear so no event is
   // lost. The counter sits at zero for one cycle after the 1->0 step and
   // reloads from there, giving a period of reload+1 cycles; a TEMPORIZADOR
   // write overrides all of that, including a coincident expiry.
   always_comb begin
      oe_d        = bus.oe;
      wr_d        = bus.WR;
      port_d      = port_q;
      cnt_d       = cnt_q;
      reload_d    = reload_q;
      expire_evt  = 1'b0;
`ifdef PUERTO_ES_IRQ_EN
      ie_d        = ie_q;
`endif

      if (wr_fire && (off == OFF_PUERTO)) begin
         port_d = bus.DatosEntrada;
      end

      underflow_d = (underflow_q & ~estado_clr)
                  | (rd_fire & (off == OFF_RX) & fifo_empty);
      overflow_d  = (overflow_q & ~estado_clr) | fifo_ovf;

      if (cnt_q != '0) begin
         cnt_d      = cnt_q - 16'd1;
         expire_evt = (cnt_q == 16'd1);
      end else if (reload_q != '0) begin
         cnt_d = reload_q;
      end
      expired_d = (expired_q & ~estado_clr) | expire_evt;

      if (wr_fire && (off == OFF_TEMP)) begin
         cnt_d     = bus.DatosEntrada;
         reload_d  = bus.DatosEntrada;
         expired_d = 1'b0;
      end

`ifdef PUERTO_ES_IRQ_EN
      if (wr_fire && (off == OFF_ESTADO)) begin
         ie_d = bus.DatosEntrada[EST_IE];
      end
`endif
   end

   // State registers; reset also re-arms both strobe edge detectors.
   always_ff @(posedge Reloj) begin
      if (!Reiniciar) begin
         oe_q        <= 1'b0;
         wr_q        <= 1'b0;
         port_q      <= '0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
         expired_q   <= 1'b0;
         cnt_q       <= '0;
         reload_q    <= '0;
`ifdef PUERTO_ES_IRQ_EN
         ie_q        <= 1'b0;
`endif
      end else begin
         oe_q        <= oe_d;
         wr_q        <= wr_d;
         port_q      <= port_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
         expired_q   <= expired_d;
         cnt_q       <= cnt_d;
         reload_q    <= reload_d;
`ifdef PUERTO_ES_IRQ_EN
         ie_q        <= ie_d;
`endif
      end
   end

   assign EntradaListo = ~fifo_full & Reiniciar;
   assign PuertoSalida = port_q;

endmodule
